// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, address fields and
// the read-engine state encoding.
package sdram_pkg;

   localparam int unsigned BANK_W    = 2;
   localparam int unsigned ROW_W     = 11;
   localparam int unsigned COL_W     = 8;
   localparam int unsigned ADDR_W    = BANK_W + ROW_W + COL_W;
   localparam int unsigned SA_W      = 12;
   localparam int unsigned DQ_W      = 16;
   localparam int unsigned LEN_W     = 8;
   localparam int unsigned BURST_LEN = 4;

   // {cs_n, ras_n, cas_n, we_n}
   typedef logic [3:0] cmd_t;
   localparam cmd_t CMD_NOP  = 4'b0111;
   localparam cmd_t CMD_ACT  = 4'b0011;
   localparam cmd_t CMD_RD   = 4'b0101;
   localparam cmd_t CMD_WR   = 4'b0100;
   localparam cmd_t CMD_PRE  = 4'b0010;
   localparam cmd_t CMD_AREF = 4'b0001;

   // A10 high on PRECHARGE selects all banks
   localparam logic [SA_W-1:0] SA_PRE_ALL = 12'h400;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } rd_addr_t;

   typedef enum logic [3:0] {
      RD_IDLE,
      RD_REQ,
      RD_ACT,
      RD_TRCD,
      RD_READ,
      RD_DRAIN,
      RD_PRE,
      RD_TRP,
      RD_END
   } rd_state_e;

endpackage

// File: rtl/sdram_read_if.sv
// Read-engine bundle: arbiter handshake, user request/data side and the
// SDRAM command/data pins seen by the engine.
interface sdram_read_if;
   import sdram_pkg::*;

   logic              rd_en;
   logic              flag_rd_ask;
   logic              flag_rd_end;
   logic              rd_trig;
   logic [LEN_W-1:0]  rd_len;
   logic [ADDR_W-1:0] rd_addr;
   cmd_t              sdram_cmd;
   logic [SA_W-1:0]   sdram_addr;
   logic [BANK_W-1:0] sdram_bank;
   logic [DQ_W-1:0]   sdram_dq_in;
   logic [DQ_W-1:0]   rd_data;
   logic              rd_data_vld;
   logic              rd_busy;

   modport master (
      input  rd_en, rd_trig, rd_len, rd_addr, sdram_dq_in,
      output flag_rd_ask, flag_rd_end, sdram_cmd, sdram_addr, sdram_bank,
             rd_data, rd_data_vld, rd_busy
   );

   modport slave (
      output rd_en, rd_trig, rd_len, rd_addr, sdram_dq_in,
      input  flag_rd_ask, flag_rd_end, sdram_cmd, sdram_addr, sdram_bank,
             rd_data, rd_data_vld, rd_busy
   );

endinterface

// File: rtl/sdram_rd_capture.sv
// Read data capture: delays each READ strobe by the CAS latency and opens a
// burst-long window in which sdram_dq_in is registered onto rd_data.
module sdram_rd_capture
   import sdram_pkg::*;
#(
   parameter int unsigned CAS_LAT = 3
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic            rd_issue,
   input  logic [DQ_W-1:0] dq_in,
   output logic [DQ_W-1:0] rd_data,
   output logic            rd_data_vld
);

   localparam int unsigned PIPE_W = CAS_LAT + BURST_LEN - 1;

   logic [PIPE_W-1:0] issue_sh;
   logic              cap_en_c;

   // Top BURST_LEN taps cover the cycles the burst words sit on the bus
   assign cap_en_c = |issue_sh[PIPE_W-1:CAS_LAT-1];

   always_ff @(posedge sclk) begin
      if (srst) begin
         issue_sh    <= '0;
         rd_data     <= '0;
         rd_data_vld <= 1'b0;
      end else begin
         issue_sh    <= {issue_sh[PIPE_W-2:0], rd_issue};
         rd_data_vld <= cap_en_c;
         if (cap_en_c) begin
            rd_data <= dq_in;
         end
      end
   end

endmodule

// File: rtl/sdram_read.sv
// Burst-read engine: arbitrates for the command bus, opens the row, streams
// back-to-back BL4 READs and yields at burst boundaries for refresh/row end.
module sdram_read
   import sdram_pkg::*;
#(
   parameter int unsigned CAS_LAT = 3,
   parameter int unsigned T_RCD   = 2,
   parameter int unsigned T_RP    = 2
) (
   input logic          sclk,
   input logic          srst,
   sdram_read_if.master bus
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] TRCD_LAST  = CNT_W'(T_RCD - 2);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(CAS_LAT);
   localparam logic [CNT_W-1:0] TRP_LAST   = CNT_W'(T_RP - 2);
   localparam logic [CNT_W-1:0] PH_LAST    = CNT_W'(BURST_LEN - 1);

   rd_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [LEN_W-1:0]  left_q, left_d;
   cmd_t              cmd_q, cmd_d;
   logic [SA_W-1:0]   addr_q, addr_d;
   logic [BANK_W-1:0] ba_q, ba_d;
   logic              ask_q, ask_d;
   logic              end_q, end_d;
   logic              busy_q, busy_d;
   logic              issue_c;
   logic              rd_issue_c;
   rd_addr_t          trig_addr_c;

   assign trig_addr_c = rd_addr_t'(bus.rd_addr);

   // Outputs are registered from the next state so commands line up with it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      left_d  = left_q;
      cmd_d   = CMD_NOP;
      addr_d  = '0;
      ba_d    = '0;
      issue_c = 1'b0;
      unique case (state_q)
         RD_IDLE: begin
            if (bus.rd_trig && (bus.rd_len != '0)) begin
               bank_d  = trig_addr_c.bank;
               row_d   = trig_addr_c.row;
               col_d   = trig_addr_c.col & ~COL_W'(BURST_LEN - 1);
               left_d  = bus.rd_len;
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            if (bus.rd_en) begin
               state_d = RD_ACT;
               cmd_d   = CMD_ACT;
               addr_d  = SA_W'(row_q);
               ba_d    = bank_q;
            end
         end
         RD_ACT: begin
            state_d = RD_TRCD;
            cnt_d   = '0;
         end
         RD_TRCD: begin
            if (cnt_q == TRCD_LAST) begin
               state_d = RD_READ;
               cnt_d   = '0;
               issue_c = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_READ: begin
            if (cnt_q != PH_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               // Burst boundary: done, pre-empted, or column wrapped to 0
               if ((left_q == '0) || !bus.rd_en || (col_q == '0)) begin
                  state_d = RD_DRAIN;
                  if (col_q == '0) begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  issue_c = 1'b1;
               end
            end
         end
         RD_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = RD_PRE;
               cmd_d   = CMD_PRE;
               addr_d  = SA_PRE_ALL;
               ba_d    = bank_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_PRE: begin
            state_d = RD_TRP;
            cnt_d   = '0;
         end
         RD_TRP: begin
            if (cnt_q == TRP_LAST) begin
               state_d = RD_END;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_END: begin
            state_d = (left_q == '0) ? RD_IDLE : RD_REQ;
         end
         default: begin
            state_d = RD_IDLE;
         end
      endcase

      if (issue_c) begin
         cmd_d  = CMD_RD;
         addr_d = SA_W'(col_q);
         ba_d   = bank_q;
         col_d  = col_q + COL_W'(BURST_LEN);
         left_d = left_q - 1'b1;
      end

      ask_d  = (state_d == RD_REQ);
      end_d  = (state_d == RD_END);
      busy_d = (state_d != RD_IDLE);
   end

   always_ff @(posedge sclk) begin
      if (srst) begin
         state_q <= RD_IDLE;
         cnt_q   <= '0;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         left_q  <= '0;
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         ba_q    <= '0;
         ask_q   <= 1'b0;
         end_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         row_q   <= row_d;
         col_q   <= col_d;
         left_q  <= left_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         ask_q   <= ask_d;
         end_q   <= end_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.sdram_cmd   = cmd_q;
   assign bus.sdram_addr  = addr_q;
   assign bus.sdram_bank  = ba_q;
   assign bus.flag_rd_ask = ask_q;
   assign bus.flag_rd_end = end_q;
   assign bus.rd_busy     = busy_q;

   assign rd_issue_c = (cmd_q == CMD_RD);

   sdram_rd_capture #(
      .CAS_LAT (CAS_LAT)
   ) u_capture (
      .sclk        (sclk),
      .srst        (srst),
      .rd_issue    (rd_issue_c),
      .dq_in       (bus.sdram_dq_in),
      .rd_data     (bus.rd_data),
      .rd_data_vld (bus.rd_data_vld)
   );

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: behavioural SDRAM + arbiter around the engine, with
// expected READ locations and data computed from a linear address walk.
module tb_sdram_read;
   import sdram_pkg::*;

   localparam int CAS_LAT = 3;
   localparam int T_RCD   = 2;
   localparam int T_RP    = 2;

   logic sclk;
   logic srst;

   sdram_read_if bus ();

   sdram_read #(
      .CAS_LAT (CAS_LAT),
      .T_RCD   (T_RCD),
      .T_RP    (T_RP)
   ) dut (
      .sclk (sclk),
      .srst (srst),
      .bus  (bus.master)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   int checks = 0;
   int errors = 0;

   int          cyc = 0;
   bit          grant = 0;
   int          block = 0;
   bit          preempt_arm = 0;
   bit          row_open = 0;
   bit          first_rd = 0;
   logic [10:0] act_row = '0;
   int          act_cyc = 0;
   int          last_rd_cyc = 0;
   logic [1:0]  xbank = '0;
   int          end_cnt = 0;
   int          act_cnt = 0;
   int          rd_cnt = 0;
   logic [15:0] exp_q[$];
   logic [18:0] rdloc_q[$];
   logic [15:0] dq_data[16];
   bit          dq_val[16];

   function automatic logic [15:0] mem_word(input logic [1:0] b, input logic [10:0] r,
                                            input logic [7:0] c);
      return {b, r[5:0], c} ^ {r[10:6], 11'h2B5};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // One clock: observe outputs at negedge, play SDRAM/arbiter, drive inputs
   task automatic step();
      logic [18:0] loc;
      int          slot;
      @(posedge sclk);
      @(negedge sclk);
      cyc++;
      case (bus.sdram_cmd)
         CMD_ACT: begin
            act_cnt++;
            if (rdloc_q.size() == 0) begin
               check("act_unexpected", 32'(bus.sdram_cmd), 32'(CMD_NOP));
            end else begin
               loc = rdloc_q[0];
               check("act_bank", 32'(bus.sdram_bank), 32'(xbank));
               check("act_row", 32'(bus.sdram_addr), 32'({1'b0, loc[18:8]}));
            end
            row_open = 1;
            act_row  = bus.sdram_addr[10:0];
            act_cyc  = cyc;
            first_rd = 1;
         end
         CMD_RD: begin
            rd_cnt++;
            if (rdloc_q.size() == 0) begin
               check("rd_unexpected", 32'(bus.sdram_cmd), 32'(CMD_NOP));
            end else begin
               loc = rdloc_q.pop_front();
               check("rd_bank", 32'(bus.sdram_bank), 32'(xbank));
               check("rd_col", 32'(bus.sdram_addr), 32'({4'b0000, loc[7:0]}));
               check("rd_row", 32'({row_open, act_row}), 32'({1'b1, loc[18:8]}));
               if (first_rd) check("rd_trcd", 32'(cyc - act_cyc), T_RCD);
               else          check("rd_spacing", 32'(cyc - last_rd_cyc), 4);
            end
            for (int k = 0; k < 4; k++) begin
               slot = (cyc + CAS_LAT + k) % 16;
               dq_val[slot]  = 1;
               dq_data[slot] = mem_word(bus.sdram_bank, act_row, bus.sdram_addr[7:0] + 8'(k));
            end
            first_rd    = 0;
            last_rd_cyc = cyc;
            if (preempt_arm) begin
               block       = 20;
               grant       = 0;
               preempt_arm = 0;
            end
         end
         CMD_PRE: begin
            check("pre_a10", 32'(bus.sdram_addr[10]), 1);
            row_open = 0;
         end
         CMD_NOP: ;
         default: check("cmd_legal", 32'(bus.sdram_cmd), 32'(CMD_NOP));
      endcase
      if (bus.rd_data_vld) begin
         check("vld_window", 32'(row_open), 1);
         if (exp_q.size() == 0) check("extra_word", 32'(bus.rd_data_vld), 0);
         else                   check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
      if (bus.flag_rd_end) begin
         end_cnt++;
         grant = 0;
      end
      if (block > 0) begin
         block--;
         grant = 0;
      end else if (bus.flag_rd_ask && !grant && ($urandom_range(0, 1) == 1)) begin
         grant = 1;
      end
      bus.rd_en = grant;
      slot = cyc % 16;
      bus.sdram_dq_in = dq_val[slot] ? dq_data[slot] : 16'($urandom);
      dq_val[slot] = 0;
   endtask

   // Build expectations from the linear address walk, then pulse rd_trig
   task automatic start(input logic [20:0] addr, input int len, input bit pre, output int ends);
      logic [18:0] base;
      logic [18:0] lin;
      base  = {addr[18:2], 2'b00};
      xbank = addr[20:19];
      ends  = 1;
      for (int b = 0; b < len; b++) begin
         lin = base + 19'(4 * b);
         rdloc_q.push_back(lin);
         if (b > 0 && ((pre && b == 1) || lin[7:0] == 8'h00)) ends++;
      end
      for (int i = 0; i < 4 * len; i++) begin
         lin = base + 19'(i);
         exp_q.push_back(mem_word(xbank, lin[18:8], lin[7:0]));
      end
      end_cnt = 0;
      act_cnt = 0;
      rd_cnt  = 0;
      preempt_arm = pre;
      bus.rd_addr = addr;
      bus.rd_len  = 8'(len);
      bus.rd_trig = 1'b1;
      step();
      bus.rd_trig = 1'b0;
      check("busy_rise", 32'(bus.rd_busy), 1);
      check("ask_rise", 32'(bus.flag_rd_ask), 1);
   endtask

   task automatic xfer(input logic [20:0] addr, input int len, input bit pre, input bit dup);
      int ends;
      int n;
      start(addr, len, pre, ends);
      n = 0;
      while (bus.rd_busy && n < 3000) begin
         if (dup && n == 5) begin
            bus.rd_trig = 1'b1;
            bus.rd_addr = addr ^ 21'h1A5A5;
            bus.rd_len  = 8'd7;
         end
         step();
         bus.rd_trig = 1'b0;
         n++;
      end
      check("xfer_done", 32'(bus.rd_busy), 0);
      check("words_left", 32'(exp_q.size()), 0);
      check("reads_left", 32'(rdloc_q.size()), 0);
      check("read_count", 32'(rd_cnt), 32'(len));
      check("end_pulses", 32'(end_cnt), 32'(ends));
      check("act_count", 32'(act_cnt), 32'(ends));
      check("ask_idle", 32'(bus.flag_rd_ask), 0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      rdloc_q.delete();
      for (int i = 0; i < 16; i++) dq_val[i] = 0;
      row_open    = 0;
      grant       = 0;
      block       = 0;
      preempt_arm = 0;
      bus.rd_en   = 1'b0;
   endtask

   initial begin
      logic [20:0] a;
      int          len;
      int          ends;
      int          n;

      srst            = 1'b1;
      bus.rd_en       = 1'b0;
      bus.rd_trig     = 1'b0;
      bus.rd_len      = '0;
      bus.rd_addr     = '0;
      bus.sdram_dq_in = '0;
      for (int i = 0; i < 16; i++) dq_val[i] = 0;
      repeat (3) step();

      // Reset state
      check("rst_cmd", 32'(bus.sdram_cmd), 32'(CMD_NOP));
      check("rst_addr", 32'(bus.sdram_addr), 0);
      check("rst_bank", 32'(bus.sdram_bank), 0);
      check("rst_data", 32'(bus.rd_data), 0);
      check("rst_vld", 32'(bus.rd_data_vld), 0);
      check("rst_ask", 32'(bus.flag_rd_ask), 0);
      check("rst_end", 32'(bus.flag_rd_end), 0);
      check("rst_busy", 32'(bus.rd_busy), 0);
      srst = 1'b0;
      step();

      // Single burst, multi-burst, row wrap, refresh pre-emption
      xfer({2'b00, 11'd0, 8'h10}, 1, 0, 0);
      xfer({2'b01, 11'd17, 8'h00}, 3, 0, 0);
      xfer({2'b00, 11'd5, 8'hFC}, 2, 0, 0);
      xfer({2'b10, 11'd300, 8'h40}, 4, 1, 0);
      xfer({2'b11, 11'd2047, 8'hF8}, 3, 0, 0);

      // rd_len=0 is ignored
      bus.rd_addr = {2'b01, 11'd9, 8'h20};
      bus.rd_len  = 8'd0;
      bus.rd_trig = 1'b1;
      step();
      bus.rd_trig = 1'b0;
      repeat (4) step();
      check("len0_ask", 32'(bus.flag_rd_ask), 0);
      check("len0_busy", 32'(bus.rd_busy), 0);

      // rd_trig while busy is ignored
      xfer({2'b10, 11'd44, 8'h80}, 3, 0, 1);

      // Reset during RD abandons the transfer
      start({2'b01, 11'd77, 8'h30}, 4, 0, ends);
      n = 0;
      while (rd_cnt == 0 && n < 200) begin
         step();
         n++;
      end
      check("rst_wait_read", 32'(rd_cnt), 1);
      step();
      srst = 1'b1;
      step();
      check("mid_rst_cmd", 32'(bus.sdram_cmd), 32'(CMD_NOP));
      check("mid_rst_ask", 32'(bus.flag_rd_ask), 0);
      check("mid_rst_end", 32'(bus.flag_rd_end), 0);
      check("mid_rst_vld", 32'(bus.rd_data_vld), 0);
      check("mid_rst_busy", 32'(bus.rd_busy), 0);
      srst = 1'b0;
      clear_model();
      step();
      xfer({2'b01, 11'd77, 8'h30}, 2, 0, 0);

      // Randomised transfers, biased toward row ends, some pre-empted
      for (int t = 0; t < 25; t++) begin
         a   = 21'($urandom);
         len = int'($urandom_range(1, 6));
         if ($urandom_range(0, 2) == 0) a[7:4] = 4'hF;
         xfer(a, len, ($urandom_range(0, 2) == 0), 0);
         repeat (int'($urandom_range(0, 3))) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
